// File: rtl/ikbd_host_uart.sv
// Host-side 8N1 endpoint for the IKBD SCI link: RX deserialiser feeding a
// first-word-fall-through FIFO, plus an independent TX serialiser.
module ikbd_host_uart #(
  parameter int CLKS_PER_BIT = 256,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 4
) (
  input  logic             CLKx2,
  input  logic             RST,
  input  logic             rxd,
  output logic             txd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [CNT_W-1:0] rx_count,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  // Synchroniser presets to idle-high so reset never looks like a start edge.
  logic sync1_q, rs_q, rs_prev_q;

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      sync1_q   <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rs_q      <= sync1_q;
      rs_prev_q <= rs_q;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI
  } rx_state_e;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push;
  logic          fe_set;

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rs_prev_q && !rs_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rs_q) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = FULL_M1;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rs_q, rx_shift_q[7:1]};
          rx_cnt_d   = FULL_M1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          if (rs_q) begin
            rx_push    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            fe_set     = 1'b1;
            rx_state_d = RX_WAITHI;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_WAITHI: begin
        if (rs_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fifo_empty, fifo_full, fifo_pop, fifo_wr, ov_set;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_pop   = !fifo_empty && rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign fifo_wr    = rx_push && (!fifo_full || fifo_pop);
  assign ov_set     = rx_push && fifo_full && !fifo_pop;

  always_ff @(posedge CLKx2) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= rx_shift_q;
    end
  end

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign rx_count = count_q;

  logic overrun_q, frame_err_q;

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= ov_set | (overrun_q & ~clr_err);
      frame_err_q <= fe_set | (frame_err_q & ~clr_err);
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d;

  always_ff @(posedge CLKx2) begin
    if (RST) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // txd is registered, so each line level is loaded one cycle before it shows.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = tx_data;
          tx_cnt_d   = FULL_M1;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = FULL_M1;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = FULL_M1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign tx_ready = (tx_state_q == TX_IDLE);
  assign txd      = txd_q;

endmodule

// File: tb/tb_ikbd_host_uart.sv
// Self-checking bench for ikbd_host_uart: frame-level reference model plus
// directed frames, glitches, framing errors, FIFO overflow and TX loopback.
module tb_ikbd_host_uart;
  localparam int CPB   = 256;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int H     = CPB / 2;
  // Start-bit drive to push: 2 sync flops, edge detect, half bit, 9 bits.
  localparam int LAT   = 3 + H + 9 * CPB;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic rxd_drv = 1'b1;
  logic loop_en = 1'b0;
  logic rx_ready = 1'b0;
  logic tx_valid = 1'b0;
  logic clr_err = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic rxd;
  logic txd, rx_valid, tx_ready, overrun, frame_err;
  logic [7:0] rx_data;
  logic [CNT_W-1:0] rx_count;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  ikbd_host_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLKx2(clk), .RST(RST), .rxd(rxd), .txd(txd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_count(rx_count),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int pulse_at = -100;
  int rises = 0;
  int rise_cyc = 0;
  bit cmp_en = 1'b0;
  bit prev_valid = 1'b0;

  typedef struct {
    int         t;
    logic [7:0] d;
    bit         ok;
  } ev_t;

  ev_t        sched[$];
  logic [7:0] mq[$];
  bit         ovr_m, fe_m, tx_act;
  int         tx_s;
  logic [7:0] tx_b;
  bit         m_pop, m_push, m_fe_set, m_ov_set;
  ev_t        m_ev;
  logic [7:0] m_dummy;
  int         m_j;

  logic       exp_txd, exp_tx_ready, exp_valid;
  logic [7:0] exp_data;
  logic [CNT_W-1:0] exp_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic bit tx_busy(input int m);
    return tx_act && (m >= tx_s) && (m < tx_s + 10 * CPB);
  endfunction

  // Reference model: state after each rising edge, from the frame-level rules.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (RST) begin
      mq.delete();
      sched.delete();
      ovr_m  = 1'b0;
      fe_m   = 1'b0;
      tx_act = 1'b0;
    end else begin
      m_pop    = (mq.size() > 0) && rx_ready;
      m_push   = 1'b0;
      m_fe_set = 1'b0;
      if (sched.size() > 0 && sched[0].t == cyc) begin
        m_ev     = sched.pop_front();
        m_push   = m_ev.ok;
        m_fe_set = !m_ev.ok;
      end
      m_ov_set = m_push && (mq.size() == DEPTH) && !m_pop;
      if (m_pop) m_dummy = mq.pop_front();
      if (m_push && !m_ov_set) mq.push_back(m_ev.d);
      if (clr_err) begin
        ovr_m = 1'b0;
        fe_m  = 1'b0;
      end
      if (m_ov_set) ovr_m = 1'b1;
      if (m_fe_set) fe_m = 1'b1;
      if (!tx_busy(cyc - 1) && tx_valid) begin
        tx_act = 1'b1;
        tx_s   = cyc;
        tx_b   = tx_data;
        if (loop_en) sched.push_back('{t: cyc + LAT, d: tx_data, ok: 1'b1});
      end
    end
    exp_valid    = (mq.size() > 0);
    exp_data     = exp_valid ? mq[0] : 8'h00;
    exp_count    = CNT_W'(mq.size());
    exp_tx_ready = !tx_busy(cyc);
    exp_txd      = 1'b1;
    if (tx_busy(cyc)) begin
      m_j = (cyc - tx_s) / CPB;
      if (m_j == 0) exp_txd = 1'b0;
      else if (m_j <= 8) exp_txd = tx_b[m_j - 1];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("txd", 32'(txd), 32'(exp_txd));
      chk("tx_ready", 32'(tx_ready), 32'(exp_tx_ready));
      chk("rx_valid", 32'(rx_valid), 32'(exp_valid));
      chk("rx_data", 32'(rx_data), 32'(exp_data));
      chk("rx_count", 32'(rx_count), 32'(exp_count));
      chk("overrun", 32'(overrun), 32'(ovr_m));
      chk("frame_err", 32'(frame_err), 32'(fe_m));
      if (rx_valid && !prev_valid) begin
        rises++;
        rise_cyc = cyc;
      end
      prev_valid = rx_valid;
    end
  end

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (cyc == pulse_at) rx_ready = 1'b1;
      else if (cyc == pulse_at + 1) rx_ready = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low, input bit pulse_rdy,
                            output int k);
    k = cyc;
    sched.push_back('{t: k + LAT, d: b, ok: (stop_low == 0)});
    if (pulse_rdy) pulse_at = k + LAT - 1;
    rxd_drv = 1'b0;
    ticks(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      ticks(CPB);
    end
    if (stop_low > 0) begin
      rxd_drv = 1'b0;
      ticks(stop_low * CPB);
    end
    rxd_drv = 1'b1;
    ticks(CPB + 16);
    pulse_at = -100;
  endtask

  task automatic pop_check(input string name, input logic [7:0] e);
    chk(name, 32'(rx_data), 32'(e));
    rx_ready = 1'b1;
    ticks(1);
    rx_ready = 1'b0;
  endtask

  logic [7:0] exp_pop [8] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};

  initial begin
    int k, low, a;
    logic [9:0] cap;

    RST = 1'b1;
    ticks(4);
    RST = 1'b0;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    cmp_en = 1'b1;
    ticks(10);

    send_frame(8'hA5, 0, 1'b0, k);
    chk("a5_latency", 32'(rise_cyc - k), 32'd2435);
    chk("a5_rises", 32'(rises), 32'd1);
    chk("a5_count", 32'(rx_count), 32'd1);
    pop_check("a5_data", 8'hA5);
    chk("a5_popped_valid", 32'(rx_valid), 32'd0);
    chk("a5_popped_count", 32'(rx_count), 32'd0);

    rxd_drv = 1'b0;
    ticks(100);
    rxd_drv = 1'b1;
    ticks(300);
    chk("glitch_count", 32'(rx_count), 32'd0);
    chk("glitch_fe", 32'(frame_err), 32'd0);
    chk("glitch_rises", 32'(rises), 32'd1);
    send_frame(8'h3C, 0, 1'b0, k);
    chk("3c_count", 32'(rx_count), 32'd1);
    pop_check("3c_data", 8'h3C);

    send_frame(8'h55, 2, 1'b0, k);
    chk("55_fe", 32'(frame_err), 32'd1);
    chk("55_count", 32'(rx_count), 32'd0);
    clr_err = 1'b1;
    ticks(1);
    clr_err = 1'b0;
    chk("55_fe_clr", 32'(frame_err), 32'd0);
    send_frame(8'h12, 0, 1'b0, k);
    chk("12_fe", 32'(frame_err), 32'd0);
    pop_check("12_data", 8'h12);

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0, k);
    chk("fill_count", 32'(rx_count), 32'd8);
    chk("fill_overrun", 32'(overrun), 32'd1);
    chk("fill_head", 32'(rx_data), 32'h01);
    clr_err = 1'b1;
    ticks(1);
    clr_err = 1'b0;
    chk("fill_ovr_clr", 32'(overrun), 32'd0);
    send_frame(8'h0A, 0, 1'b1, k);
    chk("full_pushpop_count", 32'(rx_count), 32'd8);
    chk("full_pushpop_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < 8; i++) pop_check("drain_data", exp_pop[i]);
    chk("drain_valid", 32'(rx_valid), 32'd0);

    loop_en  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    ticks(1);
    a = cyc;
    chk("tx_accept1", 32'(tx_ready), 32'd0);
    tx_data = 8'h7E;
    low = 0;
    cap = '0;
    while (!tx_ready && low < 3000) begin
      if (low % CPB == H) cap[low / CPB] = txd;
      low++;
      ticks(1);
    end
    chk("tx_low1", 32'(low), 32'd2560);
    chk("tx_bits_c3", 32'(cap), 32'(10'b1110000110));
    ticks(1);
    chk("tx_accept2", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    low = 0;
    while (!tx_ready && low < 3000) begin
      low++;
      ticks(1);
    end
    chk("tx_low2", 32'(low), 32'd2560);
    ticks(20);
    chk("loop_count", 32'(rx_count), 32'd2);
    pop_check("loop_c3", 8'hC3);
    pop_check("loop_7e", 8'h7E);
    loop_en = 1'b0;
    ticks(10);
    chk("final_sched_empty", 32'(sched.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
